// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns one load/store request into accesses to a word-wide SRAM,
// using read-modify-write for byte and halfword stores.
module dm_access_unit #(
   parameter int unsigned MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_dmtype,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] TypeW  = 3'b000;
   localparam logic [2:0] TypeH  = 3'b001;
   localparam logic [2:0] TypeHu = 3'b010;
   localparam logic [2:0] TypeB  = 3'b011;
   localparam logic [2:0] TypeBu = 3'b100;

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWr, StResp} state_e;

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          dmtype_q, dmtype_d;
   logic [1:0]          lane_q, lane_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [31:0]         resp_rdata_q, resp_rdata_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;

   // Upper address bits are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:MEM_AW+2];

   function automatic logic is_illegal(input logic we, input logic [2:0] t, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (t)
         TypeW:   bad = (a != 2'b00);
         TypeH:   bad = a[0];
         TypeHu:  bad = a[0] | we;
         TypeB:   bad = 1'b0;
         TypeBu:  bad = we;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = w[{lane[1], 4'b0000} +: 16];
      case (t)
         TypeH:   r = {{16{h[15]}}, h};
         TypeHu:  r = {16'h0000, h};
         TypeB:   r = {{24{b[7]}}, b};
         TypeBu:  r = {24'h000000, b};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] t,
                                         input logic [1:0] lane, input logic [15:0] d);
      logic [31:0] r;
      r = w;
      if (t == TypeB) r[{lane, 3'b000} +: 8] = d[7:0];
      else            r[{lane[1], 4'b0000} +: 16] = d;
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      dmtype_d     = dmtype_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d     = req_we;
               dmtype_d = req_dmtype;
               lane_d   = req_addr[1:0];
               wdata_d  = req_wdata[15:0];
               if (is_illegal(req_we, req_dmtype, req_addr[1:0])) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = req_addr[MEM_AW+1:2];
                  if (req_we && req_dmtype == TypeW) begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = req_wdata;
                     state_d     = StWr;
                  end else begin
                     state_d = StRdReq;
                  end
               end
            end
         end
         StRdReq: state_d = StRdWait;
         StRdWait: begin
            if (we_q) begin
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_wdata_d = merge(mem_rdata, dmtype_q, lane_q, wdata_q);
               state_d     = StWr;
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = extract(mem_rdata, dmtype_q, lane_q);
               state_d      = StResp;
            end
         end
         StWr: begin
            resp_valid_d = 1'b1;
            state_d      = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         dmtype_q     <= 3'b000;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         dmtype_q     <= dmtype_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
